barrel_shifter_pipe: RTL and testbench
======================================

Name: barrel_shifter_pipe

Overview:
- 32-bit registered barrel shifter: arithmetic shift right or logical shift left by 0..31 positions in one pass.
- Sits in the datapath as the shift unit of the ALU.
- Combinational logarithmic shift network (stages of 1, 2, 4, 8, 16) followed by one output register, with a valid qualifier.

Parameters:
- WIDTH, 32, data width; must be a power of two, at least 2.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk        input   1          rising-edge clock
- rst_n      input   1          asynchronous active-low reset
- in_valid   input   1          data/direction/amount valid this cycle
- direction  input   1          1 = arithmetic shift right, 0 = logical shift left
- amount     input   SHAMT_W    shift distance, 0..WIDTH-1
- data_in    input   WIDTH      operand
- out_valid  output  1          data_out holds a new result
- data_out   output  WIDTH      shifted result

Behaviour:
- Reset:
  - rst_n low clears out_valid to 0 and data_out to 0 immediately, regardless of clk.
  - Both hold at 0 until the first rising edge after rst_n deasserts.
- Latency and valid:
  - Latency is exactly 1 cycle.
  - Inputs sampled at rising edge N appear on data_out after edge N, with out_valid = 1.
  - Throughput is one operation per cycle. There is no backpressure and no stall.
- in_valid low at an edge:
  - out_valid goes to 0.
  - data_out holds its previous value; the register is not updated.
- Right shift (direction=1):
  - data_out = data_in >>> amount.
  - Vacated MSBs are filled with data_in[WIDTH-1] (sign extension).
- Left shift (direction=0):
  - data_out = data_in << amount.
  - Vacated LSBs are filled with 0; bits shifted past the MSB are discarded.
- amount = 0: data_out = data_in in both directions.
- amount = WIDTH-1:
  - Right: every bit equals the sign bit.
  - Left: data_in[0] lands in the MSB and all other bits are 0.
- Shift network:
  - Stage k shifts by 2^k when amount[k] = 1.
  - Stage order is LSB first and is not observable at the output.
- Combinational path: the network depends only on the current inputs; there is no internal state other than the output register and out_valid.
- Reset mid-stream: a pending result is lost; after release, out_valid returns only for new in_valid.
- Inputs are don't-care while in_valid = 0.

Optional Feature:
- Macro: BARREL_SHIFTER_ROTATE_EN.
- When defined:
  - Adds input port rotate (1 bit).
  - With rotate = 1 and in_valid = 1, the operation is a rotate. Direction=1 rotates right and direction=0 rotates left, by amount; bits leaving one end re-enter at the other.
  - With rotate = 0, behaviour is identical to the shifts above.
  - Latency and valid rules are unchanged.
- When undefined: no rotate port exists, and the block performs only the arithmetic-right and logical-left shifts.

Test Plan:
- Reset: assert rst_n = 0 mid-operation with out_valid = 1 -> out_valid = 0 and data_out = 0 immediately, without a clock edge.
- Negative right sweep: direction = 1, data_in = 0x80000000, amount 0..31, in_valid = 1 every cycle.
  - Each result appears one cycle later, e.g. amount 0 -> 0x80000000, 1 -> 0xC0000000, 4 -> 0xF8000000, 31 -> 0xFFFFFFFF.
  - out_valid stays 1 throughout.
- Positive right sweep: direction = 1, data_in = 0x40000000, amount 0..31 -> 0x40000000 >> amount, e.g. 1 -> 0x20000000, 30 -> 0x00000001, 31 -> 0x00000000.
- Left sweep: direction = 0, data_in = 0x00000001, amount 0..31 -> 1 << amount, e.g. 5 -> 0x00000020, 31 -> 0x80000000.
- Valid gating: issue one op (direction = 0, amount = 4, data_in = 0x0000000F), then hold in_valid = 0 for 3 cycles.
  - Next cycle: out_valid = 1, data_out = 0x000000F0.
  - Afterwards: out_valid = 0, data_out holds 0x000000F0.
- Rotate, with BARREL_SHIFTER_ROTATE_EN defined:
  - rotate = 1, direction = 1, amount = 4, data_in = 0x0000000F -> 0xF0000000.
  - rotate = 1, direction = 0, amount = 1, data_in = 0x80000001 -> 0x00000003.

Source files
------------

// File: rtl/barrel_shifter_pipe.sv
// Registered 32-bit barrel shifter: arithmetic right / logical left by 0..WIDTH-1, one-cycle latency.
// Optional rotate mode enabled by defining BARREL_SHIFTER_ROTATE_EN.
module barrel_shifter_pipe #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               direction,
    input  logic [SHAMT_W-1:0] amount,
    input  logic [WIDTH-1:0]   data_in,
`ifdef BARREL_SHIFTER_ROTATE_EN
    input  logic               rotate,
`endif
    output logic               out_valid,
    output logic [WIDTH-1:0]   data_out
);

    logic             rot_sel;
    logic [WIDTH-1:0] stg [0:SHAMT_W];

`ifdef BARREL_SHIFTER_ROTATE_EN
    assign rot_sel = rotate;
`else
    assign rot_sel = 1'b0;
`endif

    assign stg[0] = data_in;

    // Stage k moves the word by 2^k when amount[k] is set.
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int unsigned S = 1 << k;

        assign stg[k+1] = !amount[k] ? stg[k] :
                          rot_sel    ? (direction ? {stg[k][S-1:0], stg[k][WIDTH-1:S]}
                                                  : {stg[k][WIDTH-S-1:0], stg[k][WIDTH-1:WIDTH-S]}) :
                          direction  ? {{S{stg[k][WIDTH-1]}}, stg[k][WIDTH-1:S]}
                                     : {stg[k][WIDTH-S-1:0], {S{1'b0}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out <= stg[SHAMT_W];
            end
        end
    end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe: scoreboard of expected results, checked one cycle after issue.
// Rotate scenarios are exercised when BARREL_SHIFTER_ROTATE_EN is defined.
module tb_barrel_shifter_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        direction;
    logic [4:0]  amount;
    logic [31:0] data_in;
    logic        rotate;
    logic        out_valid;
    logic [31:0] data_out;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [31:0] exp_q [$];

    barrel_shifter_pipe #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .direction (direction),
        .amount    (amount),
        .data_in   (data_in),
`ifdef BARREL_SHIFTER_ROTATE_EN
        .rotate    (rotate),
`endif
        .out_valid (out_valid),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    // Bit-at-a-time reference model.
    function automatic logic [31:0] model(input logic d, input logic [4:0] a,
                                          input logic [31:0] x, input logic r);
        logic [31:0] y;
        y = x;
        for (int i = 0; i < int'(a); i++) begin
            if (r) y = d ? {y[0], y[31:1]} : {y[30:0], y[31]};
            else   y = d ? {y[31], y[31:1]} : {y[30:0], 1'b0};
        end
        return y;
    endfunction

    // Drive one cycle of inputs (from a negedge), push the expectation, advance to the next negedge.
    task automatic step(input logic v, input logic d, input logic [4:0] a,
                        input logic [31:0] x, input logic r);
        in_valid  = v;
        direction = d;
        amount    = a;
        data_in   = x;
        rotate    = r;
        if (v) exp_q.push_back(model(d, a, x, r));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] e;
        rst_n = 1'b0; in_valid = 1'b0; direction = 1'b0; amount = '0; data_in = '0; rotate = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=00000000", data_out); end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0);
        checks++; if (out_valid !== 1'b0 || data_out !== 32'h0) begin failures++;
            $display("FAIL post_reset_idle got=%b/%h exp=0/00000000", out_valid, data_out); end
        // Reset mid-stream with a valid result on the output.
        step(1'b1, 1'b0, 5'd3, 32'h00000011, 1'b0);
        e = exp_q.pop_front();
        checks++; if (out_valid !== 1'b1 || data_out !== e) begin failures++;
            $display("FAIL pre_reset_op got=%b/%h exp=1/%h", out_valid, data_out, e); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_reset_valid got=%b exp=0", out_valid); end
        checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL async_reset_data got=%h exp=00000000", data_out); end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 5'd7, 32'h12345678, 1'b0);
        checks++; if (out_valid !== 1'b0 || data_out !== 32'h0) begin failures++;
            $display("FAIL release_idle got=%b/%h exp=0/00000000", out_valid, data_out); end
    endtask

    task automatic test_sweep(input string name, input logic d, input logic [31:0] x);
        logic [31:0] e;
        for (int a = 0; a < 32; a++) begin
            step(1'b1, d, 5'(a), x, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || data_out !== e) begin
                failures++;
                $display("FAIL %s amt=%0d got=%b/%h exp=1/%h", name, a, out_valid, data_out, e);
            end
        end
    endtask

    task automatic test_spot_values();
        logic [4:0]  a [8]  = '{5'd1, 5'd4, 5'd31, 5'd1, 5'd30, 5'd31, 5'd5, 5'd31};
        logic        d [8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] x [8]  = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h40000000,
                                32'h40000000, 32'h40000000, 32'h00000001, 32'h00000001};
        logic [31:0] e [8]  = '{32'hC0000000, 32'hF8000000, 32'hFFFFFFFF, 32'h20000000,
                                32'h00000001, 32'h00000000, 32'h00000020, 32'h80000000};
        for (int i = 0; i < 8; i++) begin
            step(1'b1, d[i], a[i], x[i], 1'b0);
            void'(exp_q.pop_front());
            checks++;
            if (data_out !== e[i]) begin
                failures++;
                $display("FAIL spot%0d got=%h exp=%h", i, data_out, e[i]);
            end
        end
    endtask

    task automatic test_valid_gating();
        step(1'b1, 1'b0, 5'd4, 32'h0000000F, 1'b0);
        void'(exp_q.pop_front());
        checks++; if (out_valid !== 1'b1 || data_out !== 32'h000000F0) begin failures++;
            $display("FAIL gate_issue got=%b/%h exp=1/000000f0", out_valid, data_out); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, $urandom_range(1), 5'($urandom), $urandom, 1'b0);
            checks++;
            if (out_valid !== 1'b0 || data_out !== 32'h000000F0) begin
                failures++;
                $display("FAIL gate_hold%0d got=%b/%h exp=0/000000f0", i, out_valid, data_out);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        logic        v;
        for (int i = 0; i < 60; i++) begin
            v = ($urandom_range(3) != 0);
            step(v, $urandom_range(1), 5'($urandom), $urandom, 1'b0);
            checks++;
            if (out_valid !== v) begin
                failures++;
                $display("FAIL b2b_valid%0d got=%b exp=%b", i, out_valid, v);
            end
            if (v) begin
                e = exp_q.pop_front();
                checks++;
                if (data_out !== e) begin
                    failures++;
                    $display("FAIL b2b_data%0d got=%h exp=%h", i, data_out, e);
                end
            end
        end
    endtask

`ifdef BARREL_SHIFTER_ROTATE_EN
    task automatic test_rotate();
        logic [31:0] e;
        step(1'b1, 1'b1, 5'd4, 32'h0000000F, 1'b1);
        void'(exp_q.pop_front());
        checks++; if (data_out !== 32'hF0000000) begin failures++;
            $display("FAIL rot_right got=%h exp=f0000000", data_out); end
        step(1'b1, 1'b0, 5'd1, 32'h80000001, 1'b1);
        void'(exp_q.pop_front());
        checks++; if (data_out !== 32'h00000003) begin failures++;
            $display("FAIL rot_left got=%h exp=00000003", data_out); end
        for (int i = 0; i < 30; i++) begin
            step(1'b1, $urandom_range(1), 5'($urandom), $urandom, $urandom_range(1));
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || data_out !== e) begin
                failures++;
                $display("FAIL rot_mix%0d got=%b/%h exp=1/%h", i, out_valid, data_out, e);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sweep("neg_right", 1'b1, 32'h80000000);
        test_sweep("pos_right", 1'b1, 32'h40000000);
        test_sweep("left",      1'b0, 32'h00000001);
        test_spot_values();
        test_valid_gating();
        test_back_to_back();
`ifdef BARREL_SHIFTER_ROTATE_EN
        test_rotate();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
